// File: rtl/avalon_mem_responder_pkg.sv
// Shared types and constants for the avalon_mem_responder local-memory endpoint.
// The LFSR constants are used only when AVALON_MEM_RESPONDER_RAND_WAIT_EN is defined.
package avalon_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST
  } t_responder_state;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, taps expressed as bit positions 15,13,12,10
  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/avalon_mem_responder_ram.sv
// Simple dual-port byte-enabled RAM with a two-stage registered read path.
// A write committed at the end of cycle T is visible to a read issued in T+1.
module avalon_mem_responder_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [ADDR_BITS-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] rd_stage_q;

  // NOTE: the array and first read stage carry no reset so they map onto block RAM;
  // only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rd_stage_q <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= rd_stage_q;
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// Burst-capable Avalon-MM responder backed by on-chip RAM, with registered waitrequest.
// Define AVALON_MEM_RESPONDER_RAND_WAIT_EN to add LFSR-driven random stalls in IDLE/WR_BURST.
`ifndef PLATFORM_PARAM_LOCAL_MEMORY_ADDR_WIDTH
  `define PLATFORM_PARAM_LOCAL_MEMORY_ADDR_WIDTH 27
`endif
`ifndef PLATFORM_PARAM_LOCAL_MEMORY_DATA_WIDTH
  `define PLATFORM_PARAM_LOCAL_MEMORY_DATA_WIDTH 512
`endif
`ifndef PLATFORM_PARAM_LOCAL_MEMORY_BURST_CNT_WIDTH
  `define PLATFORM_PARAM_LOCAL_MEMORY_BURST_CNT_WIDTH 7
`endif

module avalon_mem_responder
  import avalon_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = `PLATFORM_PARAM_LOCAL_MEMORY_ADDR_WIDTH,
  parameter int DATA_WIDTH      = `PLATFORM_PARAM_LOCAL_MEMORY_DATA_WIDTH,
  parameter int BURST_CNT_WIDTH = `PLATFORM_PARAM_LOCAL_MEMORY_BURST_CNT_WIDTH,
  parameter int MEM_ADDR_BITS   = 10,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       avs_waitrequest,
  output logic [DATA_WIDTH-1:0]      avs_readdata,
  output logic                       avs_readdatavalid,
  input  logic [BURST_CNT_WIDTH-1:0] avs_burstcount,
  input  logic [DATA_WIDTH-1:0]      avs_writedata,
  input  logic [ADDR_WIDTH-1:0]      avs_address,
  input  logic                       avs_write,
  input  logic                       avs_read,
  input  logic [DATA_WIDTH/8-1:0]    avs_byteenable,
  output logic                       protocol_error
);

  localparam logic [BURST_CNT_WIDTH-1:0] CNT_ONE  = BURST_CNT_WIDTH'(1);
  localparam logic [MEM_ADDR_BITS-1:0]   ADDR_ONE = MEM_ADDR_BITS'(1);

  t_responder_state           state_q, state_d;
  logic [BURST_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [MEM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic                       perr_d;
  logic                       accept;
  logic                       ram_we;
  logic [MEM_ADDR_BITS-1:0]   ram_waddr;
  logic                       rd_issue;
  logic [1:0]                 rd_vld_q;
  logic                       stall_d;
  logic                       unused_ok;

  // Upper address bits alias onto the RAM; the seed is only consumed by the optional LFSR.
  assign unused_ok = ^{avs_address, LFSR_SEED};

  assign accept = !avs_waitrequest;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    perr_d    = protocol_error;
    ram_we    = 1'b0;
    ram_waddr = addr_q;
    rd_issue  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && (avs_write || avs_read)) begin
          if (avs_burstcount == '0) begin
            perr_d = 1'b1;
          end else if (avs_write) begin
            ram_we    = 1'b1;
            ram_waddr = avs_address[MEM_ADDR_BITS-1:0];
            cnt_d     = avs_burstcount - CNT_ONE;
            addr_d    = avs_address[MEM_ADDR_BITS-1:0] + ADDR_ONE;
            if (avs_burstcount != CNT_ONE) state_d = WR_BURST;
          end else begin
            cnt_d   = avs_burstcount;
            addr_d  = avs_address[MEM_ADDR_BITS-1:0];
            state_d = RD_BURST;
          end
          if (avs_write && avs_read) perr_d = 1'b1;
        end
      end

      WR_BURST: begin
        if (avs_read) perr_d = 1'b1;
        if (accept && avs_write) begin
          ram_we = 1'b1;
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = IDLE;
        end
      end

      RD_BURST: begin
        rd_issue = 1'b1;
        addr_d   = addr_q + ADDR_ONE;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef AVALON_MEM_RESPONDER_RAND_WAIT_EN
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

  assign lfsr_d  = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
  // Registered with waitrequest, so a stall appears in the cycle the LFSR holds 2'b00.
  assign stall_d = (lfsr_d[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign stall_d = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      protocol_error  <= 1'b0;
      avs_waitrequest <= 1'b1;
      rd_vld_q        <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      protocol_error  <= perr_d;
      avs_waitrequest <= (state_d == RD_BURST) || stall_d;
      rd_vld_q        <= {rd_vld_q[0], rd_issue};
    end
  end

  assign avs_readdatavalid = rd_vld_q[1];

  avalon_mem_responder_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (MEM_ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(avs_writedata),
    .wbe  (avs_byteenable),
    .raddr(addr_q),
    .rdata(avs_readdata)
  );

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Self-checking bench for avalon_mem_responder: directed vectors, corner sequences,
// and random bursts against a word-array reference memory with an expected-read queue.
module tb_avalon_mem_responder;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int BCW   = 4;
  localparam int MAB   = 10;
  localparam int BEW   = DW / 8;
  localparam int DEPTH = 1 << MAB;

  typedef struct {
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  pre;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] be;
    logic [DW-1:0]  exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           avs_waitrequest;
  logic [DW-1:0]  avs_readdata;
  logic           avs_readdatavalid;
  logic [BCW-1:0] avs_burstcount = '0;
  logic [DW-1:0]  avs_writedata = '0;
  logic [AW-1:0]  avs_address = '0;
  logic           avs_write = 1'b0;
  logic           avs_read = 1'b0;
  logic [BEW-1:0] avs_byteenable = '0;
  logic           protocol_error;

  avalon_mem_responder #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .BURST_CNT_WIDTH(BCW),
    .MEM_ADDR_BITS  (MAB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .avs_waitrequest  (avs_waitrequest),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_burstcount   (avs_burstcount),
    .avs_writedata    (avs_writedata),
    .avs_address      (avs_address),
    .avs_write        (avs_write),
    .avs_read         (avs_read),
    .avs_byteenable   (avs_byteenable),
    .protocol_error   (protocol_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_until = 0;
  int idle_stalls = 0;

  logic [DW-1:0]  ref_mem [DEPTH];
  logic [DW-1:0]  expq [$];
  logic [DW-1:0]  rlog [$];
  int             vcyc [$];
  logic [DW-1:0]  wd [16];
  logic [BEW-1:0] wb [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-data scoreboard: every valid beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (avs_readdatavalid === 1'b1) begin
      vcyc.push_back(cyc);
      rlog.push_back(avs_readdata);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdv_unexpected: readdatavalid high with no read outstanding (cycle %0d)", cyc);
      end else begin
        check("rd_data", avs_readdata, expq.pop_front());
      end
    end
  end

  task automatic handshake(input bit first, output int acc);
    int n;
    n   = 0;
    acc = -1;
    while (acc < 0 && n < 200) begin
      if (avs_waitrequest === 1'b0) acc = cyc;
      else if (first && cyc > busy_until) idle_stalls++;
      @(posedge clk); #1;
      n++;
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: waitrequest held high for %0d cycles", n);
    end
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input int bc, input bit gaps, input bit inj_read);
    logic [MAB-1:0] a;
    int acc;
    a = addr[MAB-1:0];
    for (int i = 0; i < ((bc == 0) ? 1 : bc); i++) begin
      avs_write      = 1'b1;
      avs_writedata  = wd[i];
      avs_byteenable = wb[i];
      avs_address    = (i == 0) ? addr : AW'($urandom);
      avs_burstcount = (i == 0) ? BCW'(bc) : BCW'($urandom);
      handshake(i == 0, acc);
      avs_write = 1'b0;
      if (acc >= 0 && bc != 0) begin
        for (int b = 0; b < BEW; b++)
          if (wb[i][b]) ref_mem[a][b*8 +: 8] = wd[i][b*8 +: 8];
        a = a + 1'b1;
      end
      if (inj_read && i == 0) begin
        avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input int bc, output int acc);
    logic [MAB-1:0] a;
    avs_read       = 1'b1;
    avs_address    = addr;
    avs_burstcount = BCW'(bc);
    handshake(1'b1, acc);
    avs_read = 1'b0;
    if (acc >= 0 && bc != 0) begin
      a = addr[MAB-1:0];
      for (int i = 0; i < bc; i++) begin
        expq.push_back(ref_mem[a]);
        a = a + 1'b1;
      end
      busy_until = acc + bc;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d read beats never returned", expq.size());
      expq.delete();
    end
  endtask

  task automatic read_one(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    int acc, n;
    rd_burst(addr, 1, acc);
    n = 0;
    while (avs_readdatavalid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, cyc - acc, 3);
    check({name, "_data"}, avs_readdata, exp);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    avs_read = 1'b0;
    avs_write = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    expq.delete();
    busy_until = cyc + 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    int acc, nv;
    logic [AW-1:0] ra;
    int rbc;

    tbl[0] = '{16'h0005, 16'h0005, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5};
    tbl[1] = '{16'h0010, 16'h0010, 32'hFFFF_FFFF, 32'h0000_0000, 4'h1, 32'hFFFF_FF00};
    tbl[2] = '{16'h0011, 16'h0011, 32'h1234_5678, 32'hAABB_CCDD, 4'h6, 32'h12BB_CC78};
    tbl[3] = '{16'h03FF, 16'h03FF, 32'h0000_0000, 32'hDEAD_BEEF, 4'h8, 32'hDE00_0000};
    tbl[4] = '{16'h0407, 16'h0007, 32'h1111_1111, 32'h2222_2222, 4'h0, 32'h1111_1111};
    tbl[5] = '{16'h8408, 16'h0008, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D};

    // Reset values and waitrequest release timing
    repeat (2) @(posedge clk);
    #1;
    check("rst_waitrequest", avs_waitrequest, 1);
    check("rst_readdatavalid", avs_readdatavalid, 0);
    check("rst_readdata", avs_readdata, 0);
    check("rst_protocol_error", protocol_error, 0);
    reset = 1'b0;
    busy_until = cyc + 1;
    check("rst_wait_first_cycle", avs_waitrequest, 1);
    @(posedge clk); #1;
`ifndef AVALON_MEM_RESPONDER_RAND_WAIT_EN
    check("rst_wait_release", avs_waitrequest, 0);
`endif

    // Bring RAM and model to a known all-zero image
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    for (int j = 0; j < 8; j++) begin wd[j] = '0; wb[j] = '1; end
    for (int k = 0; k < DEPTH / 8; k++) wr_burst(AW'(k * 8), 8, 1'b0, 1'b0);

    // Directed single-beat vectors: byte enables and upper-address aliasing
    for (int i = 0; i < 6; i++) begin
      wd[0] = tbl[i].pre;   wb[0] = '1;
      wr_burst(tbl[i].wr_addr, 1, 1'b0, 1'b0);
      wd[0] = tbl[i].wdata; wb[0] = tbl[i].be;
      wr_burst(tbl[i].wr_addr, 1, 1'b0, 1'b0);
      read_one($sformatf("vec%0d", i), tbl[i].rd_addr, tbl[i].exp);
    end

    // 4-beat burst wrapping from DEPTH-2 through 0,1
    for (int j = 0; j < 4; j++) begin wd[j] = DW'(j + 1); wb[j] = '1; end
    wr_burst(AW'(DEPTH - 2), 4, 1'b0, 1'b0);
    vcyc.delete();
    rlog.delete();
    rd_burst(AW'(DEPTH - 2), 4, acc);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("rd_burst_wait_%0d", k), avs_waitrequest, 1);
      @(posedge clk); #1;
    end
`ifndef AVALON_MEM_RESPONDER_RAND_WAIT_EN
    check("rd_burst_wait_release", avs_waitrequest, 0);
`endif
    drain();
    check("wrap_beats", vcyc.size(), 4);
    if (vcyc.size() == 4) begin
      check("wrap_first_latency", vcyc[0] - acc, 3);
      check("wrap_last_latency", vcyc[3] - acc, 6);
      for (int k = 0; k < 4; k++) check($sformatf("wrap_data_%0d", k), rlog[k], k + 1);
    end

    // burstcount 0 write is dropped and flags an error
    wd[0] = 32'h5555_5555; wb[0] = '1;
    wr_burst(16'h0020, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("perr_bc0", protocol_error, 1);
    read_one("bc0_dropped", 16'h0020, 32'h0);

    apply_reset();
    check("perr_cleared", protocol_error, 0);

    // Read during WR_BURST is flagged, ignored, and the flag is sticky
    wd[0] = 32'h0000_1111; wd[1] = 32'h0000_2222; wb[0] = '1; wb[1] = '1;
    vcyc.delete();
    wr_burst(16'h0030, 2, 1'b0, 1'b1);
    check("perr_read_in_wr", protocol_error, 1);
    repeat (5) begin @(posedge clk); #1; end
    check("perr_sticky", protocol_error, 1);
    check("no_rdv_from_wr_read", vcyc.size(), 0);
    rd_burst(16'h0030, 2, acc);
    drain();

    // Simultaneous read and write in IDLE: write kept, read dropped
    apply_reset();
    vcyc.delete();
    avs_write = 1'b1; avs_read = 1'b1; avs_address = 16'h0040; avs_burstcount = 4'd1;
    avs_writedata = 32'h0BAD_F00D; avs_byteenable = '1;
    handshake(1'b1, acc);
    avs_write = 1'b0; avs_read = 1'b0;
    if (acc >= 0) ref_mem[10'h040] = 32'h0BAD_F00D;
    repeat (5) begin @(posedge clk); #1; end
    check("perr_rw_both", protocol_error, 1);
    check("no_rdv_from_dropped_read", vcyc.size(), 0);
    read_one("both_write_kept", 16'h0040, 32'h0BAD_F00D);

    // Reset at beat 2 of an 8-beat read
    apply_reset();
    for (int j = 0; j < 8; j++) begin wd[j] = $urandom; wb[j] = '1; end
    wr_burst(16'h0100, 8, 1'b0, 1'b0);
    rd_burst(16'h0100, 8, acc);
    nv = 0;
    for (int n = 0; n < 20 && nv < 2; n++) begin
      @(posedge clk); #1;
      if (avs_readdatavalid === 1'b1) nv++;
    end
    check("mid_burst_beats_seen", nv, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_rdv", avs_readdatavalid, 0);
    check("rst_mid_wait", avs_waitrequest, 1);
    check("rst_mid_rdata", avs_readdata, 0);
    reset = 1'b0;
    expq.delete();
    busy_until = cyc + 1;
    @(posedge clk); #1;
    check("rst_mid_rdv_after", avs_readdatavalid, 0);
    check("rst_mid_perr", protocol_error, 0);
`ifndef AVALON_MEM_RESPONDER_RAND_WAIT_EN
    check("rst_mid_wait_release", avs_waitrequest, 0);
`endif
    read_one("post_rst", 16'h0103, wd[3]);

    // Random bursts against the reference memory
    for (int k = 0; k < 1000; k++) begin
      ra  = AW'($urandom);
      rbc = $urandom_range(1, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < rbc; j++) begin wd[j] = $urandom; wb[j] = BEW'($urandom); end
        wr_burst(ra, rbc, 1'b1, 1'b0);
      end else begin
        rd_burst(ra, rbc, acc);
      end
    end
    drain();
`ifdef AVALON_MEM_RESPONDER_RAND_WAIT_EN
    check("idle_stall_seen", idle_stalls > 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_mem_responder.md
# avalon_mem_responder

Burst-capable Avalon-MM responder that terminates a local-memory bank interface and backs it with on-chip RAM. It accepts write and read bursts with byte enables, applies waitrequest backpressure and returns read data on readdatavalid. It sits in the FIM slot of a local-memory bank in simulation and loopback builds, giving AFU memory traffic a deterministic, self-checking endpoint.

## Interface
- ADDR_WIDTH, `PLATFORM_PARAM_LOCAL_MEMORY_ADDR_WIDTH, word address width of avs_address
- DATA_WIDTH, `PLATFORM_PARAM_LOCAL_MEMORY_DATA_WIDTH, data bus width in bits (multiple of 8)
- BURST_CNT_WIDTH, `PLATFORM_PARAM_LOCAL_MEMORY_BURST_CNT_WIDTH, burstcount width
- MEM_ADDR_BITS, 10, log2 of RAM depth in words (≤ ADDR_WIDTH)
- LFSR_SEED, 16'hACE1, seed for random-wait generator (used only when the macro in Configuration is defined)

Ports:
- clk  in  1  bank clock
- reset  in  1  synchronous, active-high reset
- avs_waitrequest  out  1  command/write beat not accepted this cycle
- avs_readdata  out  DATA_WIDTH  read beat data
- avs_readdatavalid  out  1  avs_readdata valid this cycle
- avs_burstcount  in  BURST_CNT_WIDTH  beats in burst, sampled on first beat only
- avs_writedata  in  DATA_WIDTH  write beat data
- avs_address  in  ADDR_WIDTH  word address, sampled on first beat only
- avs_write  in  1  write beat request
- avs_read  in  1  read command request
- avs_byteenable  in  DATA_WIDTH/8  per-byte write enable
- protocol_error  out  1  sticky protocol-violation flag

## Operation
- Only clk is used; reset is synchronous and active-high.
- States: IDLE, WR_BURST, RD_BURST.
- IDLE: waitrequest low. Accepted write: beat 0 is written to RAM[address[MEM_ADDR_BITS-1:0]] under byteenable. The write counter loads burstcount-1. If the counter is nonzero, go to WR_BURST.
- IDLE: accepted read latches the address and a read counter of burstcount, then goes to RD_BURST.
- WR_BURST: each accepted write beat goes to the next address. The counter decrements, and the last beat returns to IDLE. avs_address and avs_burstcount are ignored. avs_read here sets protocol_error and is ignored.
- RD_BURST: waitrequest high. One RAM read is issued per cycle at incrementing addresses. After the last read is issued, the state returns to IDLE.
- Address increments modulo 2^MEM_ADDR_BITS. Upper address bits are ignored.
- burstcount == 0 on a first beat: command dropped, protocol_error set, state stays IDLE.
- avs_read and avs_write both high in IDLE: write processed, read dropped, protocol_error set.
- Reads observe every write accepted in an earlier cycle.
- Reset: waitrequest=1, readdatavalid=0, readdata=0, protocol_error=0, state=IDLE, and read pipeline valids are cleared. Reset mid-burst aborts the burst and discards in-flight read beats. RAM contents are not cleared.

## Timing
- Read command accepted in cycle T. The first RAM read is issued in T+1. The first readdatavalid is at T+3, and beats are contiguous through T+2+burstcount.
- The next command can be accepted at T+1+burstcount at the earliest.
- Write beat accepted in cycle T commits at the end of T.
- waitrequest is registered. It deasserts the cycle after reset drops.
- Output data comes from a register stage with no combinational path from inputs.

## Configuration
- AVALON_MEM_RESPONDER_RAND_WAIT_EN defined: in IDLE and WR_BURST, waitrequest is additionally asserted when a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset to LFSR_SEED; advances every cycle) has bits [1:0] == 2'b00. This gives about 25% stall probability.
- Not defined: waitrequest is low in IDLE and WR_BURST, and the LFSR is not built.

## Structure
- Package avalon_mem_responder_pkg: state enum t_responder_state, and the LFSR width and tap constant.
- Sub-module avalon_mem_responder_ram:
  - simple dual-port, byte-enabled RAM with DATA_WIDTH × 2^MEM_ADDR_BITS words;
  - 2-cycle registered read;
  - write-then-read ordering as stated above.
- The top level holds the FSM, counters, address generator, read valid pipeline and LFSR.

## Test plan
- Single write at address 0x5 with data 0xA5.., byteenable all ones, then a read with burstcount 1 at 0x5 -> one readdatavalid 3 cycles after acceptance, data 0xA5...
- 4-beat write burst at 2^MEM_ADDR_BITS-2 with data 1..4, then a 4-beat read at the same address -> data 1,2,3,4 read back from addresses 1022, 1023, 0, 1 (wrap).
- Write 0xFF.. then write 0x00.. with byteenable 0x1 -> readback shows only byte 0 cleared.
- burstcount 0 write, then avs_read during WR_BURST -> protocol_error=1 and held sticky, RAM unchanged for the dropped command.
- Reset asserted at beat 2 of an 8-beat read -> readdatavalid=0 from the next cycle. After reset: waitrequest=1, then 0; protocol_error=0; a new read returns correct data.
- With AVALON_MEM_RESPONDER_RAND_WAIT_EN, 1000 random bursts against a scoreboard -> no data mismatch, and waitrequest is observed high in IDLE at least once.
